ni_credit_out_stage: RTL and testbench

- Output link stage of an NI initiator, between the request packetizer and the first switch input port.
- Buffers flits from the packetizer, holds them until downstream credits are available, then drives them onto the NoC link one flit per cycle.
- Returns backpressure to the packetizer through `full`.
- Tracks downstream buffer space with a credit counter; credits are returned on BWDAUX1_in.

---
 rtl/noc_link_pkg.sv | 12 +
 rtl/flit_fifo.sv | 57 +++++
 rtl/ni_credit_out_stage.sv | 98 +++++++++
 tb/tb_ni_credit_out_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared constants for the NI-to-NoC link stages: default sizes and error-bit positions.
package noc_link_pkg;

  localparam int FLIT_WIDTH_DEF = 80;
  localparam int DEPTH_DEF      = 6;
  localparam int CREDITS_DEF    = 6;

  // Bit positions inside the sticky err vector.
  localparam int ERR_OVF  = 0;  // write attempted while the FIFO was full
  localparam int ERR_CRED = 1;  // credit returned with the counter already at maximum

endpackage

// File: rtl/flit_fifo.sv
// Flit FIFO with an arbitrary (non power-of-2) depth. Pointers wrap explicitly at DEPTH-1.
// The caller must not push while full or pop while empty.
module flit_fifo #(
  parameter int WIDTH     = 81,
  parameter int DEPTH     = 6,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 push,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rdata,
  output logic [LOG_DEPTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;

  function automatic logic [LOG_DEPTH-1:0] wrap_inc(input logic [LOG_DEPTH-1:0] p);
    return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write port.
  // NOTE: the storage array has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry and status flags derived from registered state only.
  always_comb begin
    rdata = mem[rd_ptr];
    full  = (count == LOG_DEPTH'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/ni_credit_out_stage.sv
// NI initiator output link stage: buffers packetizer flits and forwards them onto the NoC
// link one per cycle whenever downstream credits are available.
module ni_credit_out_stage
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int LOG_DEPTH   = 3,
  parameter int CREDITS     = CREDITS_DEF,
  parameter int LOG_CREDITS = 3
) (
  input  logic                   noc_clk,
  input  logic                   rst,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic                   write,
  input  logic                   tail_in,
  output logic                   full,
  output logic [FLIT_WIDTH-1:0]  FLIT_out,
  output logic                   VALID_out,
  output logic                   FWDAUX1_out,
  input  logic                   BWDAUX1_in,
  output logic [LOG_DEPTH-1:0]   occupancy,
  output logic [LOG_CREDITS-1:0] credit_cnt,
  output logic [1:0]             err
);

  localparam logic [LOG_CREDITS-1:0] CRED_MAX = LOG_CREDITS'(CREDITS);

  logic [FLIT_WIDTH:0] head;
  logic                fifo_empty;
  logic                push;
  logic                send;
  logic                cred_ovf;

  flit_fifo #(
    .WIDTH     (FLIT_WIDTH + 1),
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (noc_clk),
    .rst   (rst),
    .wdata ({tail_in, data_in}),
    .push  (push),
    .pop   (send),
    .rdata (head),
    .count (occupancy),
    .full  (full),
    .empty (fifo_empty)
  );

  // Handshake decisions: a full FIFO refuses writes even if a send frees a slot this cycle.
  // NOTE: combinational blocks use blocking assignments; every output gets a value on every path, so no latch.
  always_comb begin
    push     = write && !full;
    send     = !fifo_empty && (credit_cnt != '0);
    cred_ovf = BWDAUX1_in && !send && (credit_cnt == CRED_MAX);
  end

  // Credit counter: a send and a return in the same cycle cancel; returns saturate at CREDITS.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CRED_MAX;
    end else begin
      unique case ({send, BWDAUX1_in})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   credit_cnt <= cred_ovf ? credit_cnt : credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Link output registers: data and tail hold their last value between sends; valid pulses per send.
  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      VALID_out   <= 1'b0;
      FLIT_out    <= '0;
      FWDAUX1_out <= 1'b0;
    end else begin
      VALID_out <= send;
      if (send) begin
        FLIT_out    <= head[FLIT_WIDTH-1:0];
        FWDAUX1_out <= head[FLIT_WIDTH];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else begin
      if (write && full) err[ERR_OVF]  <= 1'b1;
      if (cred_ovf)      err[ERR_CRED] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ni_credit_out_stage.sv
// Self-checking bench for ni_credit_out_stage: a queue-based reference model predicts every
// link flit into a scoreboard; a negedge monitor compares what the DUT actually sends.
module tb_ni_credit_out_stage;

  localparam int FW      = 80;
  localparam int DEPTH   = 6;
  localparam int CREDITS = 6;

  logic          noc_clk = 1'b0;
  logic          rst     = 1'b1;
  logic [FW-1:0] data_in = '0;
  logic          write   = 1'b0;
  logic          tail_in = 1'b0;
  logic          full;
  logic [FW-1:0] FLIT_out;
  logic          VALID_out;
  logic          FWDAUX1_out;
  logic          BWDAUX1_in = 1'b0;
  logic [2:0]    occupancy;
  logic [2:0]    credit_cnt;
  logic [1:0]    err;

  ni_credit_out_stage dut (
    .noc_clk     (noc_clk),
    .rst         (rst),
    .data_in     (data_in),
    .write       (write),
    .tail_in     (tail_in),
    .full        (full),
    .FLIT_out    (FLIT_out),
    .VALID_out   (VALID_out),
    .FWDAUX1_out (FWDAUX1_out),
    .BWDAUX1_in  (BWDAUX1_in),
    .occupancy   (occupancy),
    .credit_cnt  (credit_cnt),
    .err         (err)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct packed {
    logic          tail;
    logic [FW-1:0] data;
  } flit_t;

  // Reference model state: buffered flits, available credits, sticky errors.
  flit_t      model_q[$];
  flit_t      sb[$];
  int         m_cred;
  logic [1:0] m_err;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: each cycle, VALID_out must match whether the model sent a flit, and the flit must match.
  always @(negedge noc_clk) begin
    flit_t e;
    check("valid_out", FW'(VALID_out), FW'(sb.size() != 0));
    if (VALID_out && sb.size() != 0) begin
      e = sb.pop_front();
      check("flit_out", FLIT_out, e.data);
      check("tail_out", FW'(FWDAUX1_out), FW'(e.tail));
    end
  end

  function automatic void model_reset();
    model_q.delete();
    sb.delete();
    m_cred = CREDITS;
    m_err  = '0;
  endfunction

  // One clock cycle: check visible state, apply inputs, advance the model, wait for the next sample point.
  task automatic step(input logic w, input logic t, input logic [FW-1:0] d, input logic b);
    bit m_full, m_send;
    check("occupancy", FW'(occupancy), FW'(model_q.size()));
    check("credit_cnt", FW'(credit_cnt), FW'(m_cred));
    check("full", FW'(full), FW'(model_q.size() == DEPTH));
    check("err", FW'(err), FW'(m_err));
    write      = w;
    tail_in    = t;
    data_in    = d;
    BWDAUX1_in = b;
    m_full = (model_q.size() == DEPTH);
    m_send = (model_q.size() != 0) && (m_cred != 0);
    if (m_send) sb.push_back(model_q.pop_front());
    if (m_send && !b)      m_cred--;
    else if (b && !m_send) begin
      if (m_cred == CREDITS) m_err[1] = 1'b1;
      else                   m_cred++;
    end
    if (w) begin
      if (m_full) m_err[0] = 1'b1;
      else        model_q.push_back({t, d});
    end
    @(negedge noc_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear without an edge.
  task automatic do_reset();
    write      = 1'b0;
    BWDAUX1_in = 1'b0;
    rst        = 1'b1;
    #1;
    check("rst_valid", FW'(VALID_out), '0);
    check("rst_occupancy", FW'(occupancy), '0);
    check("rst_credit", FW'(credit_cnt), FW'(CREDITS));
    check("rst_err", FW'(err), '0);
    check("rst_full", FW'(full), '0);
    model_reset();
    @(negedge noc_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge noc_clk);
    #1;
    check("reset_flit", FLIT_out, '0);
    check("reset_tail", FW'(FWDAUX1_out), '0);
    rst = 1'b0;

    // Single flit with tail: visible after the second edge.
    step(1'b1, 1'b1, 80'hA5, 1'b0);
    idle(3);

    // Credit exhaustion, then a single credit return releases exactly one flit.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, FW'(i), 1'b0);
    idle(4);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);

    // Full and overflow with credits drained to zero.
    do_reset();
    for (int i = 0; i < CREDITS; i++) step(1'b1, 1'b0, FW'(16'h100 + i), 1'b0);
    idle(3);
    for (int i = 0; i < 7; i++) step(1'b1, i[0], FW'(16'h200 + i), 1'b0);
    idle(3);

    // Simultaneous send and credit return keep the counter steady.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, FW'(16'h300 + i), 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, FW'(16'h400 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle(3);

    // Credit return while already at maximum.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    idle(2);

    // Pointer wrap over many flits, then a reset mid-stream.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, i[1], {$urandom, $urandom, 16'(i)}, ($urandom_range(0, 1) == 1));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, FW'(16'h500 + i), 1'b1);
    do_reset();
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step(($urandom_range(0, 3) != 0), 1'($urandom), {$urandom, $urandom, 16'($urandom)},
           ($urandom_range(0, 2) == 0));
    end

    // Drain everything still buffered.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    check("drain_empty", FW'(sb.size() + model_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
